// File: rtl/br_pkg.sv
// Shared definitions for branch resolution: RV32I branch funct3 codes,
// the 2-bit direction-counter state type and its saturating update.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Taken moves toward ST, not-taken toward SNT; both ends saturate.
  function automatic bht_state_t next_bht(input bht_state_t state, input logic taken);
    bht_state_t nxt;
    nxt = state;
    case (state)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset (all entries -> WNT)
//   i_rd_idx/o_rd_state combinational read port (returns pre-update value)
//   i_we/i_wr_idx/i_wr_taken  synchronous training port
module bht_table
  import br_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_W     = $clog2(BHT_ENTRIES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output bht_state_t         o_rd_state,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic               i_wr_taken
);

  bht_state_t r_table [BHT_ENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        r_table[i] <= WNT;
      end
    end else if (i_we) begin
      r_table[i_wr_idx] <= next_bht(r_table[i_wr_idx], i_wr_taken);
    end
  end

  assign o_rd_state = r_table[i_rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: computes branch/jump outcome and target,
// detects mispredictions, issues a one-shot redirect, trains the BHT and
// keeps branch / misprediction performance counters.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_valid, i_stall               EX valid / EX held this cycle
//   i_is_branch/jal/jalr, i_funct3 decoded instruction type
//   i_pc, i_imm, i_rs1_data        operands for target computation
//   i_pred_taken, i_pred_target    IF prediction carried down the pipe
//   o_signed_mode, i_eq, i_lt      comparator mode out / flags in
//   o_redirect, o_redirect_pc      fetch restart request and address
//   o_illegal_br                   branch with reserved funct3
//   i_if_pc, o_if_pred_taken       IF direction lookup
//   o_br_count, o_mispred_count    saturating performance counters
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_W     = $clog2(BHT_ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_is_branch,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_data,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  output logic        o_signed_mode,
  input  logic        i_eq,
  input  logic        i_lt,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_illegal_br,
  input  logic [31:0] i_if_pc,
  output logic        o_if_pred_taken,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  logic        w_cond;
  logic        w_legal;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_mispredict;
  logic        w_train;
  logic        w_br_inc;
  bht_state_t  w_if_state;
  logic        w_unused;

  logic        r_resolved;
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_comb begin
    w_cond  = 1'b0;
    w_legal = 1'b1;
    case (i_funct3)
      F3_BEQ:           w_cond = i_eq;
      F3_BNE:           w_cond = ~i_eq;
      F3_BLT, F3_BLTU:  w_cond = i_lt;
      F3_BGE, F3_BGEU:  w_cond = ~i_lt;
      default:          w_legal = 1'b0;
    endcase
  end

  assign o_signed_mode = (i_funct3 == F3_BLT) | (i_funct3 == F3_BGE);
  assign o_illegal_br  = i_valid & i_is_branch & ~w_legal;

  assign w_taken  = (i_is_branch & w_cond) | i_is_jal | i_is_jalr;
  assign w_target = i_is_jalr ? ((i_rs1_data + i_imm) & ~32'h1) : (i_pc + i_imm);

  assign w_mispredict  = (w_taken != i_pred_taken) |
                         (w_taken & i_pred_taken & (w_target != i_pred_target));
  assign o_redirect_pc = w_taken ? w_target : (i_pc + 32'd4);
  assign o_redirect    = i_valid & w_mispredict & ~r_resolved;

  assign w_br_inc = i_valid & i_is_branch & ~i_stall;
  assign w_train  = w_br_inc & w_legal;

  // A stalled instruction redirects on its first cycle only; the flag is
  // dropped as soon as EX advances so the next instruction starts clean.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_resolved <= 1'b0;
    end else if (!i_stall) begin
      r_resolved <= 1'b0;
    end else if (o_redirect) begin
      r_resolved <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_br_inc && (r_br_count != '1)) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (o_redirect && (r_mispred_count != '1)) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

  bht_table #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .INDEX_W     (INDEX_W)
  ) u_bht (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_idx   (i_if_pc[INDEX_W+1:2]),
    .o_rd_state (w_if_state),
    .i_we       (w_train),
    .i_wr_idx   (i_pc[INDEX_W+1:2]),
    .i_wr_taken (w_cond)
  );

  assign o_if_pred_taken = w_if_state[1];

  assign w_unused = ^{i_if_pc[31:INDEX_W+2], i_if_pc[1:0], w_if_state[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int S_RED = 0, S_RPC = 1, S_SGN = 2, S_ILL = 3,
                 S_IFP = 4, S_BRC = 5, S_MPC = 6, S_TAB = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, stall, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, rs1_data, pred_target, if_pc;
  logic        pred_taken, eq, lt;
  logic        signed_mode, redirect, illegal_br, if_pred_taken;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    int          idx;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  branch_resolve_unit #(.BHT_ENTRIES(64)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_valid         (valid),
    .i_stall         (stall),
    .i_is_branch     (is_branch),
    .i_is_jal        (is_jal),
    .i_is_jalr       (is_jalr),
    .i_funct3        (funct3),
    .i_pc            (pc),
    .i_imm           (imm),
    .i_rs1_data      (rs1_data),
    .i_pred_taken    (pred_taken),
    .i_pred_target   (pred_target),
    .o_signed_mode   (signed_mode),
    .i_eq            (eq),
    .i_lt            (lt),
    .o_redirect      (redirect),
    .o_redirect_pc   (redirect_pc),
    .o_illegal_br    (illegal_br),
    .i_if_pc         (if_pc),
    .o_if_pred_taken (if_pred_taken),
    .o_br_count      (br_count),
    .o_mispred_count (mispred_count)
  );

  function automatic logic [31:0] actual(input int sel, input int idx);
    case (sel)
      S_RED:   return {31'b0, redirect};
      S_RPC:   return redirect_pc;
      S_SGN:   return {31'b0, signed_mode};
      S_ILL:   return {31'b0, illegal_br};
      S_IFP:   return {31'b0, if_pred_taken};
      S_BRC:   return br_count;
      S_MPC:   return mispred_count;
      default: return {30'b0, dut.u_bht.r_table[idx]};
    endcase
  endfunction

  // Monitor: pops every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else begin
        a = actual(e.sel, e.idx);
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", e.name, cyc, a, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input logic [31:0] v, input string nm, input int idx = 0);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = v;
    e.idx  = idx;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; pc = 0; imm = 0; rs1_data = 0;
    pred_taken = 0; pred_target = 0; eq = 0; lt = 0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] p, input logic [31:0] im,
                        input logic e_in, input logic l_in, input logic pt, input logic [31:0] ptgt);
    idle();
    valid = 1; is_branch = 1; funct3 = f3; pc = p; imm = im;
    eq = e_in; lt = l_in; pred_taken = pt; pred_target = ptgt;
  endtask

  initial begin
    idle();
    reset = 1;
    if_pc = 32'h100;
    step();
    step();
    expect_v(S_IFP, 0, "reset_ifp");
    reset = 0;
    step();
    expect_v(S_IFP, 0, "post_reset_ifp");
    expect_v(S_BRC, 0, "reset_brc");
    expect_v(S_MPC, 0, "reset_mpc");
    expect_v(S_TAB, 1, "reset_tab0", 0);

    // BLT mispredicted not-taken
    step();
    branch(3'b100, 32'h100, 32'h20, 0, 1, 0, 0);
    expect_v(S_SGN, 1, "blt_signed");
    expect_v(S_RED, 1, "blt_redirect");
    expect_v(S_RPC, 32'h120, "blt_rpc");
    step();
    idle();
    expect_v(S_MPC, 1, "blt_mpc");
    expect_v(S_BRC, 1, "blt_brc");
    expect_v(S_TAB, 2, "blt_tab_wt", 0);
    expect_v(S_IFP, 1, "blt_ifp");

    // Three correctly-predicted taken outcomes: WT -> ST, saturates
    for (int i = 0; i < 3; i++) begin
      step();
      branch(3'b100, 32'h100, 32'h20, 0, 1, 1, 32'h120);
      expect_v(S_RED, 0, "blt_tt_redirect");
      expect_v(S_TAB, (i == 0) ? 2 : 3, "blt_tt_tab", 0);
      expect_v(S_BRC, 1 + i, "blt_tt_brc");
    end

    // Four not-taken outcomes predicted taken: ST -> WT -> WNT -> SNT -> SNT
    for (int i = 0; i < 4; i++) begin
      step();
      branch(3'b100, 32'h100, 32'h20, 0, 0, 1, 32'h120);
      expect_v(S_TAB, 3 - i, "blt_nt_tab", 0);
      expect_v(S_MPC, 1 + i, "blt_nt_mpc");
      if (i == 0) begin
        expect_v(S_RED, 1, "blt_nt_redirect");
        expect_v(S_RPC, 32'h104, "blt_nt_rpc");
      end
    end

    // JALR: (0x1003+4)&~1 = 0x1006 differs from predicted 0x1000
    step();
    idle();
    valid = 1; is_jalr = 1; pc = 32'h200; rs1_data = 32'h1003; imm = 32'h4;
    pred_taken = 1; pred_target = 32'h1000;
    expect_v(S_TAB, 0, "nt_sat_tab", 0);
    expect_v(S_BRC, 8, "nt_brc");
    expect_v(S_MPC, 5, "nt_mpc");
    expect_v(S_RED, 1, "jalr_redirect");
    expect_v(S_RPC, 32'h1006, "jalr_rpc");
    step();
    idle();
    expect_v(S_BRC, 8, "jalr_brc");
    expect_v(S_MPC, 6, "jalr_mpc");
    expect_v(S_TAB, 0, "jalr_tab", 0);

    // BNE mispredicted, stalled three cycles: one redirect, one training
    for (int i = 0; i < 4; i++) begin
      step();
      branch(3'b001, 32'h304, 32'h10, 0, 0, 0, 0);
      stall = (i < 3);
      expect_v(S_RED, (i == 0) ? 1 : 0, "bne_stall_redirect");
      expect_v(S_BRC, 8, "bne_stall_brc");
      expect_v(S_TAB, 1, "bne_stall_tab", 1);
      if (i == 0) expect_v(S_RPC, 32'h314, "bne_rpc");
    end
    step();
    idle();
    expect_v(S_BRC, 9, "bne_brc");
    expect_v(S_MPC, 7, "bne_mpc");
    expect_v(S_TAB, 2, "bne_tab", 1);

    // Illegal funct3 010: not taken, flagged, counted, not trained
    step();
    branch(3'b010, 32'h400, 32'h40, 1, 0, 0, 0);
    expect_v(S_ILL, 1, "ill_flag");
    expect_v(S_RED, 0, "ill_redirect");
    expect_v(S_SGN, 0, "ill_signed");
    expect_v(S_RPC, 32'h404, "ill_rpc");

    // Read-before-write: BEQ not-taken trains index 1 WT -> WNT
    step();
    branch(3'b000, 32'h304, 32'h8, 0, 0, 0, 0);
    if_pc = 32'h304;
    expect_v(S_BRC, 10, "ill_brc");
    expect_v(S_TAB, 0, "ill_tab", 0);
    expect_v(S_RED, 0, "beq_redirect");
    expect_v(S_ILL, 0, "beq_ill");
    expect_v(S_IFP, 1, "rbw_old_value");
    step();
    idle();
    expect_v(S_IFP, 0, "rbw_new_value");
    expect_v(S_TAB, 1, "beq_tab", 1);
    expect_v(S_BRC, 11, "beq_brc");

    // i_valid=0: nothing happens
    step();
    branch(3'b100, 32'h100, 32'h20, 0, 1, 0, 0);
    valid = 0;
    expect_v(S_RED, 0, "invalid_redirect");
    expect_v(S_ILL, 0, "invalid_ill");
    step();
    idle();
    expect_v(S_BRC, 11, "invalid_brc");
    expect_v(S_MPC, 7, "invalid_mpc");
    expect_v(S_TAB, 0, "invalid_tab", 0);

    step();
    step();
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, 0 required", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
